multicycle_control: RTL and testbench

Main control unit for the multicycle RV32I datapath. A Moore state machine sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the register file write enable, the Extend immediate select, the two operand multiplexers (PC/oldPC/RD1 and RD2/immExt/4) and the 2-bit ALUControl. It also holds in memory states until the memory handshake completes.

---
 rtl/riscv_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_control_alu_decoder.sv | 47 ++++
 rtl/multicycle_control.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control unit: state encoding,
// opcodes, and the select/ALU encodings driven onto the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    // Opcodes (Instr[6:0])
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // ALUControl
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    // ALUOp handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALUSrcB
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps (ALUOp, funct3, funct7b5, op[5]) to ALUControl and flags
// funct3 values the datapath cannot execute. The unsupported flag depends on
// funct3 only, so it is valid in DECODE even though ALUOp is "add" there.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op_b5,
    output logic [1:0] alu_control,
    output logic       unsupported
);

    // Select the ALU operation and classify funct3 legality
    always_comb begin
        alu_control = ALU_ADD;
        unsupported = 1'b0;
        case (funct3)
            3'b000:  unsupported = 1'b0;
            3'b110:  unsupported = 1'b0;
            3'b111:  unsupported = 1'b0;
            default: unsupported = 1'b1;
        endcase
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        // op[5] separates R-type from I-ALU; addi has no sub form
                        if (op_b5 && funct7b5) begin
                            alu_control = ALU_SUB;
                        end else begin
                            alu_control = ALU_ADD;
                        end
                    end
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main Moore control FSM of the multicycle RV32I datapath.
// Optional feature macro: RISCV_JAL_EN (enables the JAL state and jal decode;
// when undefined, jal is treated as an illegal instruction).
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    state_e     state_q;
    state_e     state_d;
    logic       pc_write_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       illegal_s;
    logic [1:0] result_src_s;
    logic [1:0] src_a_s;
    logic [1:0] src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] alu_control_s;
    logic       funct_unsupported_s;
    logic [1:0] imm_src_s;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op_s),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op_b5       (op[5]),
        .alu_control (alu_control_s),
        .unsupported (funct_unsupported_s)
    );

    // State register; low reset returns the sequencer to FETCH immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        state_d      = state_q;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        result_src_s = RES_ALUOUT;
        src_a_s      = SRCA_PC;
        src_b_s      = SRCB_RD2;
        alu_op_s     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight to the PC while the instruction is latched
                src_a_s      = SRCA_PC;
                src_b_s      = SRCB_FOUR;
                result_src_s = RES_ALURESULT;
                ir_write_s   = mem_ready;
                pc_write_s   = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                src_a_s = SRCA_OLDPC;
                src_b_s = SRCB_IMM;
                case (op)
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW:    state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_unsupported_s) begin
                            state_d = S_ILLEGAL;
                        end else begin
                            state_d = S_EXECR;
                        end
                    end
                    OP_IALU: begin
                        if (funct_unsupported_s) begin
                            state_d = S_ILLEGAL;
                        end else begin
                            state_d = S_EXECI;
                        end
                    end
                    OP_BEQ: begin
                        if (funct3 == 3'b000) begin
                            state_d = S_BEQ;
                        end else begin
                            state_d = S_ILLEGAL;
                        end
                    end
`ifdef RISCV_JAL_EN
                    OP_JAL:   state_d = S_JAL;
`endif
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                src_a_s = SRCA_RD1;
                src_b_s = SRCB_IMM;
                if (op == OP_LW) begin
                    state_d = S_MEMREAD;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                result_src_s = RES_MEMDATA;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe held for the whole handshake, including wait cycles
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECR: begin
                src_a_s  = SRCA_RD1;
                src_b_s  = SRCB_RD2;
                alu_op_s = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                src_a_s  = SRCA_RD1;
                src_b_s  = SRCB_IMM;
                alu_op_s = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_s = RES_ALUOUT;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
`ifdef RISCV_JAL_EN
            S_JAL: begin
                // PC takes the jump target from ALUOut; ALU forms oldPC+4 for rd
                src_a_s      = SRCA_OLDPC;
                src_b_s      = SRCB_FOUR;
                result_src_s = RES_ALUOUT;
                pc_write_s   = 1'b1;
                state_d      = S_ALUWB;
            end
`endif
            S_BEQ: begin
                src_a_s      = SRCA_RD1;
                src_b_s      = SRCB_RD2;
                alu_op_s     = ALUOP_SUB;
                result_src_s = RES_ALUOUT;
                pc_write_s   = Zero;
                state_d      = S_FETCH;
            end
            S_ILLEGAL: begin
                // PC already advanced in FETCH, so just flag and move on
                illegal_s = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        imm_src_s = IMM_I;
        case (op)
            OP_LW:   imm_src_s = IMM_I;
            OP_IALU: imm_src_s = IMM_I;
            OP_SW:   imm_src_s = IMM_S;
            OP_BEQ:  imm_src_s = IMM_B;
`ifdef RISCV_JAL_EN
            OP_JAL:  imm_src_s = IMM_J;
`endif
            default: imm_src_s = IMM_I;
        endcase
    end

    // Write enables are suppressed while reset is held low
    assign PCWrite    = reset & pc_write_s;
    assign IRWrite    = reset & ir_write_s;
    assign MemWrite   = reset & mem_write_s;
    assign RegWrite   = reset & reg_write_s;
    assign illegal    = reset & illegal_s;
    assign AdrSrc     = adr_src_s;
    assign ResultSrc  = result_src_s;
    assign ALUSrcA    = src_a_s;
    assign ALUSrcB    = src_b_s;
    assign ALUControl = alu_control_s;
    assign ImmSrc     = imm_src_s;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model
// (list of states each instruction walks through, plus a per-state output
// table) is compared against the DUT every cycle, with directed cases pinned
// to hand-computed state sequences followed by randomized traffic.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    // Model: remaining walk of the current instruction
    int  path[$];
    int  idx;
    bit  done;

    // Per-cycle trace of the current instruction
    int         st_q[$];
    logic       mw_q[$], rw_q[$], pcw_q[$], ill_q[$], irw_q[$];
    logic [1:0] alu_q[$], rs_q[$];

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a given state number, straight from the state table
    function automatic logic [19:0] expect_out(input int s, input logic [6:0] o,
                                               input logic [2:0] f3, input logic f7,
                                               input logic z, input logic mr,
                                               input logic rst_n_v);
        logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0, ill = 1'b0;
        logic [1:0] rs = 2'b00, asa = 2'b00, asb = 2'b00, alu = 2'b00, imm = 2'b00;
        case (s)
            0: begin asb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            1: begin asa = 2'b01; asb = 2'b01; end
            2: begin asa = 2'b10; asb = 2'b01; end
            3: adr = 1'b1;
            4: begin rs = 2'b01; rw = 1'b1; end
            5: begin adr = 1'b1; mw = 1'b1; end
            6, 7: begin
                asa = 2'b10;
                asb = (s == 7) ? 2'b01 : 2'b00;
                if (f3 == 3'b110)              alu = 2'b11;
                else if (f3 == 3'b111)         alu = 2'b10;
                else if (s == 6 && f7 == 1'b1) alu = 2'b01;
                else                           alu = 2'b00;
            end
            8: rw = 1'b1;
            9: begin asa = 2'b01; asb = 2'b10; pcw = 1'b1; end
            10: begin asa = 2'b10; alu = 2'b01; pcw = z; end
            11: ill = 1'b1;
            default: ;
        endcase
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
`ifdef RISCV_JAL_EN
            7'b1101111: imm = 2'b11;
`endif
            default:    imm = 2'b00;
        endcase
        if (!rst_n_v) begin
            pcw = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; ill = 1'b0;
        end
        return {4'(s), pcw, adr, mw, irw, rw, rs, asa, asb, alu, imm, ill};
    endfunction

    // Set up the instruction inputs and the state walk it should take
    task automatic load_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        bit alu_ok;
        op = o; funct3 = f3; funct7b5 = f7;
        idx = 0; done = 1'b0;
        alu_ok = (f3 == 3'd0) || (f3 == 3'd6) || (f3 == 3'd7);
        case (o)
            7'b0000011: path = {0, 1, 2, 3, 4};
            7'b0100011: path = {0, 1, 2, 5};
            7'b0110011: if (alu_ok) path = {0, 1, 6, 8}; else path = {0, 1, 11};
            7'b0010011: if (alu_ok) path = {0, 1, 7, 8}; else path = {0, 1, 11};
            7'b1100011: if (f3 == 3'd0) path = {0, 1, 10}; else path = {0, 1, 11};
`ifdef RISCV_JAL_EN
            7'b1101111: path = {0, 1, 9, 8};
`endif
            default:    path = {0, 1, 11};
        endcase
    endtask

    task automatic clear_trace();
        st_q.delete(); mw_q.delete(); rw_q.delete(); pcw_q.delete();
        ill_q.delete(); irw_q.delete(); alu_q.delete(); rs_q.delete();
    endtask

    // One clock: drive, compare against the model, then advance the model
    task automatic step(input logic mr, input logic z, input logic rst_n_v);
        logic [19:0] exp_v, act_v;
        int s;
        @(negedge clk);
        reset = rst_n_v; mem_ready = mr; Zero = z;
        #1;
        s = rst_n_v ? path[idx] : 0;
        exp_v = expect_out(s, op, funct3, funct7b5, z, mr, rst_n_v);
        act_v = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_outputs op=%b f3=%b model_state=%0d got %h want %h",
                     op, funct3, s, act_v, exp_v);
        end
        st_q.push_back(int'(state)); mw_q.push_back(MemWrite); rw_q.push_back(RegWrite);
        pcw_q.push_back(PCWrite); ill_q.push_back(illegal); irw_q.push_back(IRWrite);
        alu_q.push_back(ALUControl); rs_q.push_back(ResultSrc);
        @(posedge clk);
        if (!rst_n_v) begin
            idx = 0;
        end else if (!((s == 0 || s == 3 || s == 5) && !mr)) begin
            idx++;
            if (idx == path.size()) begin
                idx = 0;
                done = 1'b1;
            end
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        check_int({name, "_len"}, st_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < st_q.size(); i++)
            check_int(name, st_q[i], exp[i]);
    endtask

    // Directed run: optional stall cycles injected in one chosen state
    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int stall_state, input int stalls);
        int left = stalls;
        int cnt = 0;
        logic mr;
        clear_trace();
        load_instr(o, f3, f7);
        while (!done && cnt < 40) begin
            mr = 1'b1;
            if (path[idx] == stall_state && left > 0) begin
                mr = 1'b0;
                left--;
            end
            step(mr, z, 1'b1);
            cnt++;
        end
        if (!done) check_int("directed_timeout", 0, 1);
    endtask

    function automatic int count_ones(input logic q[$]);
        int n = 0;
        foreach (q[i]) n += int'(q[i]);
        return n;
    endfunction

    initial begin
        int e[$];
        logic [6:0] ro;
        logic [2:0] rf3;
        int cnt;
        reset = 1'b0; mem_ready = 1'b1; Zero = 1'b0;
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;

        // Reset held with mem_ready high: FETCH, no enables
        clear_trace();
        load_instr(7'b0000011, 3'b010, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_int("rst_state", st_q[1], 0);
        check_int("rst_irwrite", int'(irw_q[1]), 0);
        check_int("rst_pcwrite", int'(pcw_q[1]), 0);

        // lw straight through; first released cycle latches the instruction
        run(7'b0000011, 3'b010, 1'b0, 1'b0, -1, 0);
        e = {0, 1, 2, 3, 4}; check_seq("lw_seq", e);
        check_int("release_irwrite", int'(irw_q.size() > 0 ? irw_q[0] : 1'b0), 1);
        check_int("memwb_regwrite", int'(rw_q.size() > 4 ? rw_q[4] : 1'b0), 1);
        check_int("memwb_resultsrc", int'(rs_q.size() > 4 ? rs_q[4] : 2'b00), 1);

        // sw with three wait cycles in MEMWRITE
        run(7'b0100011, 3'b010, 1'b0, 1'b0, 5, 3);
        e = {0, 1, 2, 5, 5, 5, 5}; check_seq("sw_seq", e);
        check_int("sw_memwrite_cycles", count_ones(mw_q), 4);

        // R-type sub
        run(7'b0110011, 3'b000, 1'b1, 1'b0, -1, 0);
        e = {0, 1, 6, 8}; check_seq("sub_seq", e);
        check_int("sub_alucontrol", int'(alu_q.size() > 2 ? alu_q[2] : 2'b00), 1);
        check_int("sub_regwrite", int'(rw_q.size() > 3 ? rw_q[3] : 1'b0), 1);

        // beq taken / not taken
        run(7'b1100011, 3'b000, 1'b0, 1'b1, -1, 0);
        e = {0, 1, 10}; check_seq("beq_t_seq", e);
        check_int("beq_taken_pcwrite", int'(pcw_q.size() > 2 ? pcw_q[2] : 1'b0), 1);
        run(7'b1100011, 3'b000, 1'b0, 1'b0, -1, 0);
        check_int("beq_nt_pcwrite", int'(pcw_q.size() > 2 ? pcw_q[2] : 1'b1), 0);

        // jal
        run(7'b1101111, 3'b000, 1'b0, 1'b0, -1, 0);
`ifdef RISCV_JAL_EN
        e = {0, 1, 9, 8}; check_seq("jal_seq", e);
        check_int("jal_pcwrite", int'(pcw_q.size() > 2 ? pcw_q[2] : 1'b0), 1);
`else
        e = {0, 1, 11}; check_seq("jal_seq", e);
        check_int("jal_illegal_pulses", count_ones(ill_q), 1);
`endif

        // Unknown opcode and unsupported beq funct3
        run(7'b1111111, 3'b000, 1'b0, 1'b0, -1, 0);
        e = {0, 1, 11}; check_seq("badop_seq", e);
        check_int("badop_illegal_pulses", count_ones(ill_q), 1);
        run(7'b1100011, 3'b001, 1'b0, 1'b0, -1, 0);
        e = {0, 1, 11}; check_seq("beq_f3_seq", e);

        // FETCH waits on mem_ready
        run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2);
        e = {0, 0, 0, 1, 2, 3, 4}; check_seq("fetch_wait_seq", e);

        // Randomized traffic with random waits and occasional mid-instruction reset
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0:       ro = 7'b0000011;
                1:       ro = 7'b0100011;
                2:       ro = 7'b0110011;
                3:       ro = 7'b0010011;
                4:       ro = 7'b1100011;
                5:       ro = 7'b1101111;
                6:       ro = 7'b1111111;
                default: ro = 7'($urandom_range(0, 127));
            endcase
            case ($urandom_range(0, 3))
                0:       rf3 = 3'b000;
                1:       rf3 = 3'b110;
                2:       rf3 = 3'b111;
                default: rf3 = 3'($urandom_range(0, 7));
            endcase
            clear_trace();
            load_instr(ro, rf3, 1'($urandom_range(0, 1)));
            cnt = 0;
            while (!done && cnt < 80) begin
                step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 59) != 0));
                cnt++;
            end
            if (!done) check_int("random_timeout", 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
